// File: rtl/wb_stage_pkg.sv
// Shared types for the MEM->WB stage buffer: occupancy state, entry layout, default widths.
package wb_stage_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int REG_IDX_W_DEF = 5;
  localparam int REG_ZERO      = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic                     rd_e;
    logic [REG_IDX_W_DEF-1:0] rd_idx;
    logic [DATA_W_DEF-1:0]    rd_data;
  } entry_t;

endpackage

// File: rtl/wb_stage_slot.sv
// One entry register with valid bit; clear wins over load, reset zeroes the payload.
module wb_stage_slot
  import wb_stage_pkg::*;
#(
  parameter int W = $bits(entry_t)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr_in,
  input  logic         ld_in,
  input  logic [W-1:0] dat_in,
  output logic         vld_out,
  output logic [W-1:0] dat_out
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clr_in) begin
      vld_d = 1'b0;
    end else if (ld_in) begin
      vld_d = 1'b1;
      dat_d = dat_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_out = vld_q;
  assign dat_out = dat_q;

endmodule

// File: rtl/wb_stage_buf.sv
// MEM->WB stage register with valid/ready, flush and optional skid slot (WB_STAGE_SKID_EN).
// Latency: 1 cycle from input accept to output present.
// Backpressure: skid build registers in_ready = (occ != 2); default build in_ready = !out_valid | out_ready.
module wb_stage_buf
  import wb_stage_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 rdE_in,
  input  logic [REG_IDX_W-1:0] rdIdx_in,
  input  logic [DATA_W-1:0]    rdData_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rdE_out,
  output logic [REG_IDX_W-1:0] rdIdx_out,
  output logic [DATA_W-1:0]    rdData_out,
  output logic [1:0]           occ_out
);

  typedef struct packed {
    logic                 rd_e;
    logic [REG_IDX_W-1:0] rd_idx;
    logic [DATA_W-1:0]    rd_data;
  } ent_t;

  localparam int ENT_W = $bits(ent_t);

  occ_e occ_q, occ_d;
  ent_t in_ent, m_ent, m_nxt;
  logic m_vld, m_ld, m_clr;
  logic in_fire, out_fire;

  // x0 writes are killed here so WB never needs to special-case them.
  always_comb begin
    in_ent.rd_e    = rdE_in & (rdIdx_in != REG_IDX_W'(REG_ZERO));
    in_ent.rd_idx  = rdIdx_in;
    in_ent.rd_data = rdData_in;
  end

`ifdef WB_STAGE_SKID_EN
  ent_t s_ent;
  logic s_vld, s_ld, s_clr, m_from_s;

  assign in_ready = (occ_q != OCC_TWO);
  assign m_nxt    = m_from_s ? s_ent : in_ent;

  wb_stage_slot #(.W(ENT_W)) u_slot_s (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (s_clr),
    .ld_in   (s_ld),
    .dat_in  (in_ent),
    .vld_out (s_vld),
    .dat_out (s_ent)
  );
`else
  assign in_ready = !out_valid | out_ready;
  assign m_nxt    = in_ent;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    m_ld  = 1'b0;
    m_clr = 1'b0;
`ifdef WB_STAGE_SKID_EN
    s_ld     = 1'b0;
    s_clr    = 1'b0;
    m_from_s = 1'b0;
`endif
    if (flush_in) begin
      occ_d = OCC_EMPTY;
      m_clr = 1'b1;
`ifdef WB_STAGE_SKID_EN
      s_clr = 1'b1;
`endif
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            occ_d = OCC_ONE;
            m_ld  = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            m_ld = 1'b1;
          end else if (out_fire) begin
            occ_d = OCC_EMPTY;
            m_clr = 1'b1;
`ifdef WB_STAGE_SKID_EN
          end else if (in_fire) begin
            occ_d = OCC_TWO;
            s_ld  = 1'b1;
`endif
          end
        end
        OCC_TWO: begin
`ifdef WB_STAGE_SKID_EN
          // in_ready was low, so only the skid entry can move forward.
          if (out_fire && s_vld) begin
            occ_d    = OCC_ONE;
            m_ld     = 1'b1;
            m_from_s = 1'b1;
            s_clr    = 1'b1;
          end
`endif
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  wb_stage_slot #(.W(ENT_W)) u_slot_m (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (m_clr),
    .ld_in   (m_ld),
    .dat_in  (m_nxt),
    .vld_out (m_vld),
    .dat_out (m_ent)
  );

  assign out_valid  = m_vld;
  assign rdE_out    = m_ent.rd_e & m_vld;
  assign rdIdx_out  = m_ent.rd_idx;
  assign rdData_out = m_ent.rd_data;
  assign occ_out    = occ_q;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed + random bench for wb_stage_buf with a queue scoreboard; works with or without WB_STAGE_SKID_EN.
module tb_wb_stage_buf;

`ifdef WB_STAGE_SKID_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, in_valid, in_ready, rdE_in;
  logic [4:0]  rdIdx_in;
  logic [31:0] rdData_in;
  logic        out_valid, out_ready, rdE_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;
  logic [1:0]  occ_out;

  logic dir_or, rand_or, rand_mode, exp_e_in;
  assign out_ready = rand_mode ? rand_or : dir_or;

  typedef struct packed {
    logic        e;
    logic [4:0]  idx;
    logic [31:0] d;
  } txn_t;

  txn_t sb_q[$];
  txn_t got, expv, prev_out;
  logic prev_vld, prev_stall;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  wb_stage_buf dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rdE_in    (rdE_in),
    .rdIdx_in  (rdIdx_in),
    .rdData_in (rdData_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdE_out   (rdE_out),
    .rdIdx_out (rdIdx_out),
    .rdData_out(rdData_out),
    .occ_out   (occ_out)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    rand_or = 1'b1;
    forever begin
      @(posedge clk_in);
      #1 rand_or = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor/scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (rst_in) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      got = {rdE_out, rdIdx_out, rdData_out};
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got idx %0d data %0h, expected nothing", rdIdx_out, rdData_out);
        end else begin
          expv = sb_q.pop_front();
          chk("sb_order", 64'(got), 64'(expv));
        end
      end
      if (!out_valid) chk("rde_gated", 64'(rdE_out), 64'd0);
      if (prev_stall) chk("stall_hold", 64'({out_valid, got}), 64'({prev_vld, prev_out}));
      if (flush_in) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back({exp_e_in, rdIdx_in, rdData_in});
      prev_stall = out_valid && !out_ready && !flush_in;
      prev_vld   = out_valid;
      prev_out   = got;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic e, input logic [4:0] idx, input logic [31:0] d, input logic ee);
    int w;
    w = 0;
    in_valid  = 1'b1;
    rdE_in    = e;
    rdIdx_in  = idx;
    rdData_in = d;
    exp_e_in  = ee;
    @(negedge clk_in);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk_in);
    end
    if (!in_ready) chk("send_timeout", 64'(w), 64'd0);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [4:0]  ri;
    logic [31:0] rd;
    logic        re;
    int          start, w;
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ri;
    logic [31:0] rd;
    logic        re;
    int          start, w;
    rst_in = 1'b1; flush_in = 1'b0; in_valid = 1'b1; rdE_in = 1'b1;
    rdIdx_in = 5'd3; rdData_in = 32'hAAAA; dir_or = 1'b1; rand_mode = 1'b0; exp_e_in = 1'b1;

    // Reset held two cycles with in_valid high
    @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rde", 64'(rdE_out), 64'd0);
    chk("rst_idx", 64'(rdIdx_out), 64'd0);
    chk("rst_data", 64'(rdData_out), 64'd0);
    chk("rst_occ", 64'(occ_out), 64'd0);
    step();
    rst_in = 1'b0; in_valid = 1'b0;
    @(negedge clk_in);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_occ", 64'(occ_out), 64'd0);

    // Pass-through
    step();
    send(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk_in);
    chk("pt_valid", 64'(out_valid), 64'd1);
    chk("pt_rde", 64'(rdE_out), 64'd1);
    chk("pt_idx", 64'(rdIdx_out), 64'd5);
    chk("pt_data", 64'(rdData_out), 64'hDEADBEEF);

    // x0 write kill
    step();
    send(1'b1, 5'd0, 32'h12345678, 1'b0);
    @(negedge clk_in);
    chk("x0_valid", 64'(out_valid), 64'd1);
    chk("x0_rde", 64'(rdE_out), 64'd0);
    chk("x0_data", 64'(rdData_out), 64'h12345678);

    // Back-pressure: fill, hold, release
    step();
    dir_or = 1'b0;
    for (int k = 0; k < K; k++) send(1'b1, 5'(k + 1), 32'h100 + 32'(k + 1), 1'b1);
    in_valid = 1'b1; rdE_in = 1'b1; rdIdx_in = 5'(K + 1); rdData_in = 32'h100 + 32'(K + 1);
    repeat (3) begin
      @(negedge clk_in);
      chk("bp_occ", 64'(occ_out), 64'(K));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_idx", 64'(rdIdx_out), 64'd1);
    end
    step();
    dir_or = 1'b1;
    for (int k = K; k < 3; k++) send(1'b1, 5'(k + 1), 32'h100 + 32'(k + 1), 1'b1);
    repeat (4) step();
    chk("bp_drained", 64'(sb_q.size()), 64'd0);

    // Flush with a held backlog and a same-cycle input
    dir_or = 1'b0;
    for (int k = 0; k < K; k++) send(1'b1, 5'(7 + k), 32'h700 + 32'(k), 1'b1);
    flush_in = 1'b1; in_valid = 1'b1; rdE_in = 1'b1; rdIdx_in = 5'd9; rdData_in = 32'h9999; exp_e_in = 1'b1;
    step();
    flush_in = 1'b0; in_valid = 1'b0;
    @(negedge clk_in);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_occ", 64'(occ_out), 64'd0);
    step();
    dir_or = 1'b1;
    repeat (4) begin
      @(negedge clk_in);
      chk("fl_stays_empty", 64'(out_valid), 64'd0);
    end

    // Full throughput with continuous out_ready
    step();
    start = cyc;
    for (int i = 0; i < 20; i++) send(1'b1, 5'((i % 31) + 1), 32'(i) * 32'h01010101, 1'b1);
    chk("throughput_cycles", 64'(cyc - start), 64'd20);

    // Random traffic with random out_ready
    rand_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ri = 5'($urandom_range(0, 31));
      rd = $urandom;
      re = 1'($urandom_range(0, 1));
      send(re, ri, rd, re && (ri != 5'd0));
    end
    rand_mode = 1'b0;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      step();
      w++;
    end
    step();
    chk("final_drain", 64'(sb_q.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
